// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - memory bus controller: RAM, LED and switch access for a control FSM
module mem_bus_ctrl #(
    parameter int RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        ready,
    output logic        bus_err,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw,
    output logic [7:0]  led
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2,
        WR_DONE = 2'd3
    } state_t;

    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_read_data;
    logic        r_ready;
    logic        r_bus_err;
    logic [7:0]  r_ram_addr;
    logic [15:0] r_ram_din;
    logic        r_ram_we;
    logic [7:0]  r_led;
    logic [7:0]  r_sw_sync1;
    logic [7:0]  r_sw_sync2;

    logic        w_is_ram;
    logic        w_is_led;
    logic        w_is_sw;

    // Address decode: lower 256 words are RAM, two single-word peripherals above
    assign w_is_ram = (mem_addr[8] == 1'b0);
    assign w_is_led = (mem_addr == 9'h100);
    assign w_is_sw  = (mem_addr == 9'h140);

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_sync1 <= 8'h00;
            r_sw_sync2 <= 8'h00;
        end else begin
            r_sw_sync1 <= sw;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    // Request FSM; ready and ram_we are single-cycle pulses cleared by default
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_read_data <= 16'h0000;
            r_ready     <= 1'b0;
            r_bus_err   <= 1'b0;
            r_ram_addr  <= 8'h00;
            r_ram_din   <= 16'h0000;
            r_ram_we    <= 1'b0;
            r_led       <= 8'h00;
        end else begin
            r_ready  <= 1'b0;
            r_ram_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_cmd == CMD_WRITE) begin
                        if (w_is_ram) begin
                            r_ram_addr <= mem_addr[7:0];
                            r_ram_din  <= write_data;
                            r_ram_we   <= 1'b1;
                        end else if (w_is_led) begin
                            r_led <= write_data[7:0];
                        end else begin
                            r_bus_err <= 1'b1;
                        end
                        r_ready <= 1'b1;
                        r_state <= WR_DONE;
                    end else if (mem_cmd == CMD_READ) begin
                        if (w_is_ram) begin
                            r_ram_addr <= mem_addr[7:0];
                            r_cnt      <= 3'(RAM_LATENCY);
                            r_state    <= RD_WAIT;
                        end else if (w_is_sw) begin
                            r_read_data <= {8'h00, r_sw_sync2};
                            r_ready     <= 1'b1;
                            r_state     <= RD_DONE;
                        end else begin
                            // Error completions finish through WR_DONE so read_data is untouched
                            r_bus_err <= 1'b1;
                            r_ready   <= 1'b1;
                            r_state   <= WR_DONE;
                        end
                    end else if (mem_cmd == CMD_RSVD) begin
                        r_bus_err <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= WR_DONE;
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_read_data <= ram_dout;
                        r_ready     <= 1'b1;
                        r_state     <= RD_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RD_DONE: r_state <= IDLE;
                WR_DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign read_data = r_read_data;
    assign ready     = r_ready;
    assign bus_err   = r_bus_err;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_we    = r_ram_we;
    assign led       = r_led;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic [1:0]  cmd   [3];
    logic [8:0]  addr  [3];
    logic [15:0] wd    [3];
    logic [15:0] rd    [3];
    logic        rdy   [3];
    logic        err   [3];
    logic [7:0]  ra    [3];
    logic [15:0] rdin  [3];
    logic        rwe   [3];
    logic [15:0] rdout [3];
    logic [7:0]  led   [3];

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    mem_bus_ctrl #(.RAM_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .mem_cmd(cmd[0]), .mem_addr(addr[0]), .write_data(wd[0]),
        .read_data(rd[0]), .ready(rdy[0]), .bus_err(err[0]), .ram_addr(ra[0]), .ram_din(rdin[0]),
        .ram_we(rwe[0]), .ram_dout(rdout[0]), .sw(sw), .led(led[0])
    );
    mem_bus_ctrl #(.RAM_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .mem_cmd(cmd[1]), .mem_addr(addr[1]), .write_data(wd[1]),
        .read_data(rd[1]), .ready(rdy[1]), .bus_err(err[1]), .ram_addr(ra[1]), .ram_din(rdin[1]),
        .ram_we(rwe[1]), .ram_dout(rdout[1]), .sw(sw), .led(led[1])
    );
    mem_bus_ctrl #(.RAM_LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .mem_cmd(cmd[2]), .mem_addr(addr[2]), .write_data(wd[2]),
        .read_data(rd[2]), .ready(rdy[2]), .bus_err(err[2]), .ram_addr(ra[2]), .ram_din(rdin[2]),
        .ram_we(rwe[2]), .ram_dout(rdout[2]), .sw(sw), .led(led[2])
    );

    // RAM models: write on the clock edge, read returns the addressed word
    always @(posedge clk) begin
        if (rwe[0]) mem0[ra[0]] <= rdin[0];
        if (rwe[1]) mem1[ra[1]] <= rdin[1];
        if (rwe[2]) mem2[ra[2]] <= rdin[2];
    end
    assign rdout[0] = mem0[ra[0]];
    assign rdout[1] = mem1[ra[1]];
    assign rdout[2] = mem2[ra[2]];

    // Count cycles with ram_we high per instance
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rwe[k]) we_cnt[k] <= we_cnt[k] + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a request in cycle T; lat is the cycle offset where ready is first seen (-1 on timeout)
    task automatic req(input int k, input logic [1:0] c, input logic [8:0] a,
                       input logic [15:0] d, output int lat);
        @(posedge clk); #1;
        cmd[k] = c; addr[k] = a; wd[k] = d;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rdy[k]) begin
                lat = n;
                break;
            end
        end
        cmd[k] = 2'b00;
    endtask

    initial begin
        int lat;
        int we0;
        int nrdy;
        logic [5:0] pat;
        logic [15:0] d1, d2;

        reset = 1'b1;
        sw    = 8'h00;
        for (int k = 0; k < 3; k++) begin
            cmd[k] = 2'b00; addr[k] = 9'h000; wd[k] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_read_data", 32'(rd[0]), 32'h0);
        chk("rst_ready", 32'(rdy[0]), 32'h0);
        chk("rst_bus_err", 32'(err[0]), 32'h0);
        chk("rst_ram_addr", 32'(ra[0]), 32'h0);
        chk("rst_ram_din", 32'(rdin[0]), 32'h0);
        chk("rst_ram_we", 32'(rwe[0]), 32'h0);
        chk("rst_led", 32'(led[0]), 32'h0);

        // Write 0xBEEF to 0x012 then read it back, latency 1
        we0 = we_cnt[0];
        req(0, 2'b01, 9'h012, 16'hBEEF, lat);
        chk("wr_ram_ready_lat", 32'(lat), 32'd1);
        chk("wr_ram_we_hi", 32'(rwe[0]), 32'h1);
        chk("wr_ram_addr", 32'(ra[0]), 32'h12);
        chk("wr_ram_din", 32'(rdin[0]), 32'hBEEF);
        @(negedge clk);
        chk("wr_ram_we_lo", 32'(rwe[0]), 32'h0);
        chk("wr_ram_we_cycles", 32'(we_cnt[0] - we0), 32'd1);
        req(0, 2'b10, 9'h012, 16'h0000, lat);
        chk("rd_l1_ready_lat", 32'(lat), 32'd2);
        chk("rd_l1_data", 32'(rd[0]), 32'hBEEF);

        // Latency 3: read 0x0FF holding 0x1234
        req(1, 2'b01, 9'h0FF, 16'h1234, lat);
        chk("wr_l3_ready_lat", 32'(lat), 32'd1);
        req(1, 2'b10, 9'h0FF, 16'h0000, lat);
        chk("rd_l3_ready_lat", 32'(lat), 32'd4);
        chk("rd_l3_data", 32'(rd[1]), 32'h1234);

        // LED write and switch read
        sw = 8'h3C;
        req(0, 2'b01, 9'h100, 16'h00A5, lat);
        chk("wr_led_ready_lat", 32'(lat), 32'd1);
        chk("wr_led_value", 32'(led[0]), 32'hA5);
        req(0, 2'b10, 9'h140, 16'h0000, lat);
        chk("rd_sw_ready_lat", 32'(lat), 32'd1);
        chk("rd_sw_data", 32'(rd[0]), 32'h003C);
        chk("no_err_yet", 32'(err[0]), 32'h0);

        // Back-to-back switch reads with mem_cmd held
        sw = 8'h5A;
        repeat (3) @(posedge clk);
        #1 cmd[0] = 2'b10; addr[0] = 9'h140;
        pat = 6'b0; d1 = 16'h0; d2 = 16'h0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            pat[n] = rdy[0];
            if (n == 1) d1 = rd[0];
            if (n == 3) d2 = rd[0];
            if (n == 4) cmd[0] = 2'b00;
        end
        chk("b2b_ready_pattern", 32'(pat), 32'h0A);
        chk("b2b_data1", 32'(d1), 32'h005A);
        chk("b2b_data2", 32'(d2), 32'h005A);

        // Reserved command and unmapped read set sticky bus_err
        we0 = we_cnt[0];
        req(0, 2'b11, 9'h012, 16'h1111, lat);
        chk("rsvd_ready_lat", 32'(lat), 32'd1);
        chk("rsvd_bus_err", 32'(err[0]), 32'h1);
        chk("rsvd_read_data", 32'(rd[0]), 32'h005A);
        req(0, 2'b10, 9'h1FF, 16'h0000, lat);
        chk("unmap_ready_lat", 32'(lat), 32'd1);
        chk("unmap_bus_err", 32'(err[0]), 32'h1);
        chk("unmap_read_data", 32'(rd[0]), 32'h005A);
        @(negedge clk);
        chk("err_no_ram_we", 32'(we_cnt[0] - we0), 32'd0);
        chk("err_led_kept", 32'(led[0]), 32'hA5);
        req(0, 2'b10, 9'h140, 16'h0000, lat);
        chk("err_sticky", 32'(err[0]), 32'h1);

        // Latency 4: normal read, then reset during RD_WAIT
        req(2, 2'b01, 9'h030, 16'hCAFE, lat);
        chk("wr_l4_ready_lat", 32'(lat), 32'd1);
        req(2, 2'b10, 9'h030, 16'h0000, lat);
        chk("rd_l4_ready_lat", 32'(lat), 32'd5);
        chk("rd_l4_data", 32'(rd[2]), 32'hCAFE);
        @(posedge clk); #1;
        cmd[2] = 2'b10; addr[2] = 9'h030;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1; cmd[2] = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        nrdy = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rdy[2]) nrdy++;
            if (n == 0) chk("abort_ram_we", 32'(rwe[2]), 32'h0);
        end
        chk("abort_no_ready", 32'(nrdy), 32'd0);
        chk("abort_read_data", 32'(rd[2]), 32'h0);
        chk("abort_bus_err_cleared", 32'(err[0]), 32'h0);
        chk("abort_led_cleared", 32'(led[0]), 32'h0);
        req(2, 2'b10, 9'h030, 16'h0000, lat);
        chk("post_abort_ready_lat", 32'(lat), 32'd5);
        chk("post_abort_data", 32'(rd[2]), 32'hCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
